fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the torv32 pipeline: it replaces the single fetch register pair with a DEPTH-entry prefetch queue. It drives a synchronous instruction memory with one-cycle read latency and presents instruction/PC pairs to decode over a valid/ready handshake. A redirect from execute (jump or taken branch) flushes the queue and squashes any read already in flight.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory read port, execute redirect and decode handshake.
// The fetch queue drives the master side; the surrounding pipeline uses the slave side.
interface fetch_queue_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [31:0]       out_pc;
    logic [LVL_W-1:0]  level;

    modport master (
        output imem_req, imem_addr, out_valid, out_ir, out_pc, level,
        input  imem_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_ir, out_pc, level,
        output imem_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: DEPTH-entry queue fed by a one-cycle-latency
// synchronous imem, drained by decode over valid/ready, flushed by redirects from execute.
module fetch_queue #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             issue;
    logic [SUM_W-1:0] demand;

    // Admission: only issue a read if its response is guaranteed a free slot.
    always_comb begin
        pop    = (count != '0) & bus.out_ready & ~bus.redirect;
        push   = inflight & ~bus.redirect;
        demand = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
        issue  = ~reset & ~bus.redirect & (demand < SUM_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect) begin
            // Flush wins over everything, including a response arriving this cycle.
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ir: bus.imem_data, pc: inflight_pc};
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc[ADDR_W-1:0];
    assign bus.out_valid = (count != '0);
    assign bus.out_ir    = mem[rd_ptr].ir;
    assign bus.out_pc    = mem[rd_ptr].pc;
    assign bus.level     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_queue;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned LVL_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [15:0] l;
        l = a[15:0];
        return {~l, l};
    endfunction

    // Instruction memory: one-cycle latency, garbage when not requested.
    always @(posedge clk) begin
        bus.imem_data <= bus.imem_req ? word_of(32'(bus.imem_addr)) : $urandom();
    end

    // Reference model: decoded instruction stream as a queue of PCs plus one pending read.
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;
    always @(posedge clk or posedge reset) begin
        int pop_e;
        bit req_e;
        if (reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = RESET_PC;
        end else if (bus.redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            pop_e = (mq.size() != 0 && bus.out_ready) ? 1 : 0;
            req_e = (mq.size() + int'(m_pend) - pop_e) < int'(DEPTH);
            if (pop_e != 0) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            m_pend = req_e;
            if (req_e) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
    end

    task automatic drive(input bit rdy, input bit rdr, input logic [31:0] rpc);
        @(negedge clk);
        bus.out_ready   = rdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after reset release.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        n_vec++; if (bus.level !== LVL_W'(0)) begin n_err++; $display("FAIL reset_level got=%0d want=0", bus.level); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC[ADDR_W-1:0]) begin n_err++; $display("FAIL first_req got=%b/%h want=1/%h", bus.imem_req, bus.imem_addr, RESET_PC[ADDR_W-1:0]); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL latency_n1 got=%b want=0", bus.out_valid); end
        e = RESET_PC;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_ir !== word_of(e)) begin n_err++; $display("FAIL stream%0d got=%b/%h/%h want=1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_ir, e, word_of(e)); end
            e = e + 32'd4;
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        nreq = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 32'h0);
            if (bus.imem_req === 1'b1) begin
                n_vec++; if (bus.imem_addr !== ADDR_W'(4 * nreq)) begin n_err++; $display("FAIL bp_addr got=%h want=%h", bus.imem_addr, ADDR_W'(4 * nreq)); end
                nreq++;
            end
        end
        n_vec++; if (nreq !== 4) begin n_err++; $display("FAIL bp_nreq got=%0d want=4", nreq); end
        n_vec++; if (bus.level !== LVL_W'(DEPTH)) begin n_err++; $display("FAIL bp_level got=%0d want=%0d", bus.level, DEPTH); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin n_err++; $display("FAIL bp_drain%0d got=%b/%h want=1/%h", k, bus.out_valid, bus.out_pc, 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0103);
        n_vec++; if (bus.level !== LVL_W'(3) || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rd_pre got=%0d/%b want=3/1", bus.level, bus.out_valid); end
        n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_in_redirect got=%b want=0", bus.imem_req); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.level !== LVL_W'(0) || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush got=%0d/%b want=0/0", bus.level, bus.out_valid); end
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin n_err++; $display("FAIL rd_newreq got=%b/%h want=1/0100", bus.imem_req, bus.imem_addr); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rd_r2 got=%b want=0", bus.out_valid); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_ir !== word_of(32'h100)) begin n_err++; $display("FAIL rd_r3 got=%b/%h/%h want=1/00000100/%h", bus.out_valid, bus.out_pc, bus.out_ir, word_of(32'h100)); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin n_err++; $display("FAIL rd_r4 got=%b/%h want=1/00000104", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        int npop;
        e = RESET_PC;
        npop = 0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            drive(i[0] == 1'b0, 1'b0, 32'h0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_vec++; if (bus.out_pc !== e || bus.out_ir !== word_of(e)) begin n_err++; $display("FAIL wrap_pc got=%h/%h want=%h/%h", bus.out_pc, bus.out_ir, e, word_of(e)); end
                e = e + 32'd4;
                npop++;
            end
        end
        n_vec++; if (npop < 12) begin n_err++; $display("FAIL wrap_count got=%0d want>=12", npop); end
    endtask

    task automatic test_midreset();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.level !== LVL_W'(0) || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL midreset_clear got=%b/%0d/%b want=0/0/0", bus.out_valid, bus.level, bus.imem_req); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC[ADDR_W-1:0]) begin n_err++; $display("FAIL midreset_req got=%b/%h want=1/%h", bus.imem_req, bus.imem_addr, RESET_PC[ADDR_W-1:0]); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_n1 got=%b want=0", bus.out_valid); end
        drive(1'b1, 1'b0, 32'h0);
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC || bus.out_ir !== word_of(RESET_PC)) begin n_err++; $display("FAIL midreset_first got=%b/%h/%h want=1/%h/%h", bus.out_valid, bus.out_pc, bus.out_ir, RESET_PC, word_of(RESET_PC)); end
    endtask

    task automatic test_random();
        int  pop_e;
        bit  req_e;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom());
            pop_e = (mq.size() != 0 && bus.out_ready && !bus.redirect) ? 1 : 0;
            req_e = !bus.redirect && ((mq.size() + int'(m_pend) - pop_e) < int'(DEPTH));
            n_vec++; if (bus.out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d got=%b want=%b", i, bus.out_valid, mq.size() != 0); end
            n_vec++; if (bus.level !== LVL_W'(mq.size())) begin n_err++; $display("FAIL rnd_level@%0d got=%0d want=%0d", i, bus.level, mq.size()); end
            n_vec++; if (bus.imem_req !== req_e) begin n_err++; $display("FAIL rnd_req@%0d got=%b want=%b", i, bus.imem_req, req_e); end
            n_vec++; if (bus.imem_addr !== m_fpc[ADDR_W-1:0]) begin n_err++; $display("FAIL rnd_addr@%0d got=%h want=%h", i, bus.imem_addr, m_fpc[ADDR_W-1:0]); end
            if (mq.size() != 0) begin
                n_vec++; if (bus.out_pc !== mq[0] || bus.out_ir !== word_of(mq[0])) begin n_err++; $display("FAIL rnd_head@%0d got=%h/%h want=%h/%h", i, bus.out_pc, bus.out_ir, mq[0], word_of(mq[0])); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
